// File: rtl/return_scheduler.sv
// Coin-return sequencer: idle timeout / user trigger starts a greedy return of the
// held amount in 1000/500/100 coins through a valid/ack hopper handshake.
module return_scheduler #(
  parameter int unsigned TIMEOUT = 10,
  parameter int unsigned TOTAL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         i_input_coin,
  input  logic [3:0]         i_select_item,
  input  logic               i_trigger_return,
  input  logic [TOTAL_W-1:0] i_current_total,
  input  logic               i_coin_ack,
  output logic               o_coin_valid,
  output logic [2:0]         o_return_coin,
  output logic [31:0]        o_wait_time,
  output logic               o_busy,
  output logic               o_done
);

  // Arithmetic is done at least 32 bits wide so coin constants never truncate.
  localparam int unsigned AW = (TOTAL_W > 32) ? TOTAL_W : 32;

  typedef enum logic [2:0] {IDLE, COUNT, LOAD, DISPENSE, DONE} state_t;

  state_t             state;
  logic [TOTAL_W-1:0] remaining;
  logic               activity;
  logic [TOTAL_W-1:0] load_value;
  logic [TOTAL_W-1:0] after_ack;

  function automatic logic [2:0] pick_coin(input logic [TOTAL_W-1:0] amt);
    logic [AW-1:0] a;
    a = AW'(amt);
    if (a >= AW'(1000))     return 3'b100;
    else if (a >= AW'(500)) return 3'b010;
    else if (a >= AW'(100)) return 3'b001;
    else                    return 3'b000;
  endfunction

  function automatic logic [AW-1:0] coin_value(input logic [2:0] coin);
    case (coin)
      3'b100:  return AW'(1000);
      3'b010:  return AW'(500);
      3'b001:  return AW'(100);
      default: return '0;
    endcase
  endfunction

  assign activity   = (|i_input_coin) || (|i_select_item);
  assign load_value = TOTAL_W'(AW'(i_current_total) - (AW'(i_current_total) % AW'(100)));
  // The presented coin never exceeds remaining, so this cannot underflow.
  assign after_ack  = TOTAL_W'(AW'(remaining) - coin_value(o_return_coin));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      remaining     <= '0;
      o_coin_valid  <= 1'b0;
      o_return_coin <= 3'b000;
      o_wait_time   <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE, COUNT: begin
          if (i_trigger_return) begin
            state       <= LOAD;
            o_wait_time <= '0;
            o_busy      <= 1'b1;
          end else if (activity) begin
            state       <= COUNT;
            o_wait_time <= 32'(TIMEOUT);
          end else if (state == COUNT) begin
            if (o_wait_time <= 32'd1) begin
              state       <= LOAD;
              o_wait_time <= '0;
              o_busy      <= 1'b1;
            end else begin
              o_wait_time <= o_wait_time - 32'd1;
            end
          end
        end
        LOAD: begin
          remaining <= load_value;
          if (load_value != '0) begin
            state         <= DISPENSE;
            o_coin_valid  <= 1'b1;
            o_return_coin <= pick_coin(load_value);
          end else begin
            state  <= DONE;
            o_done <= 1'b1;
          end
        end
        DISPENSE: begin
          if (i_coin_ack) begin
            remaining <= after_ack;
            if (after_ack == '0) begin
              state         <= DONE;
              o_coin_valid  <= 1'b0;
              o_return_coin <= 3'b000;
              o_done        <= 1'b1;
            end else begin
              o_return_coin <= pick_coin(after_ack);
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/return_scheduler.md
RETURN_SCHEDULER -- requirements
Module: return_scheduler

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 10, the idle cycles before automatic coin return.
REQ-002 SHALL provide parameter TOTAL_W, default 16, the width of the held-amount bus.
REQ-003 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL provide port i_input_coin, input, 3, coin-insert strobes (bit0=100, bit1=500, bit2=1000).
REQ-006 SHALL provide port i_select_item, input, 4, item-select strobes.
REQ-007 SHALL provide port i_trigger_return, input, 1, user return request.
REQ-008 SHALL provide port i_current_total, input, TOTAL_W, amount currently held, in units of 1.
REQ-009 SHALL provide port i_coin_ack, input, 1, hopper acknowledge of the presented coin.
REQ-010 SHALL provide port o_coin_valid, output, 1, coin presented to the hopper.
REQ-011 SHALL provide port o_return_coin, output, 3, one-hot coin being dispensed (same bit map as i_input_coin).
REQ-012 SHALL provide port o_wait_time, output, 32, cycles remaining before automatic return.
REQ-013 SHALL provide port o_busy, output, 1, return sequence in progress.
REQ-014 SHALL provide port o_done, output, 1, one-cycle pulse when a return sequence ends.

Function
REQ-015 SHALL implement the states IDLE, COUNT, LOAD, DISPENSE and DONE.
REQ-016 SHALL treat any cycle with (|i_input_coin) or (|i_select_item) as "activity".
REQ-017 IDLE: on activity, SHALL go to COUNT with o_wait_time=TIMEOUT on the next edge.
REQ-018 COUNT: on activity, SHALL reload o_wait_time=TIMEOUT; otherwise SHALL decrement it by 1 per cycle.
REQ-019 COUNT with o_wait_time==1 and no activity SHALL set o_wait_time=0 and go to LOAD.
REQ-020 i_trigger_return high in IDLE or COUNT SHALL go to LOAD and clear o_wait_time; trigger SHALL take priority over same-cycle activity.
REQ-021 LOAD (one cycle) SHALL capture remaining = i_current_total - (i_current_total mod 100), then go to DISPENSE if remaining>0, else to DONE.
REQ-022 DISPENSE SHALL assert o_coin_valid with o_return_coin = the largest coin <= remaining (1000, then 500, then 100).
REQ-023 o_coin_valid and o_return_coin SHALL hold stable until i_coin_ack is sampled high while valid.
REQ-024 On ack, SHALL subtract the coin value from remaining; if the result is 0, SHALL go to DONE, else SHALL present the next coin in the following cycle.
REQ-025 Back-to-back acks SHALL dispense one coin per cycle; i_coin_ack while o_coin_valid=0 SHALL be ignored.
REQ-026 The remainder below 100 SHALL NOT be returned and SHALL NOT stall the sequence.
REQ-027 DONE SHALL pulse o_done for exactly one cycle, then go to IDLE.
REQ-028 o_busy SHALL be 1 in LOAD, DISPENSE and DONE, and 0 otherwise.
REQ-029 Activity and trigger SHALL be ignored while o_busy=1; changes to i_current_total after LOAD SHALL be ignored.
REQ-030 o_return_coin SHALL be 0 whenever o_coin_valid=0.
REQ-031 remaining SHALL be TOTAL_W bits wide, and subtraction SHALL never underflow.

Reset
REQ-032 Asserting reset SHALL immediately force state=IDLE, o_wait_time=0, o_coin_valid=0, o_return_coin=0, o_busy=0, o_done=0, remaining=0.
REQ-033 Reset mid-DISPENSE SHALL abort the sequence without emitting o_done.
REQ-034 After reset is released, the block SHALL wait in IDLE for activity.

Verification
REQ-035 Timeout: one 500 coin strobe, no further inputs, total=1600, ack always high -> o_wait_time reads 10..1, then LOAD, then coins 1000, 500, 100 on consecutive cycles, then o_done.
REQ-036 Reload: a strobe at o_wait_time=3 -> o_wait_time=10 on the next cycle, and no return occurs.
REQ-037 Trigger: trigger with total=250 -> one coin 100, a second coin 100, then o_done; the remainder 50 is not returned.
REQ-038 Backpressure: total=1000, ack held low for 5 cycles -> o_coin_valid=1 and o_return_coin=3'b100 stable for all 5 cycles, and one coin is dispensed on ack.
REQ-039 Zero total: trigger with total=0 -> LOAD, then DONE, o_done pulses, and o_coin_valid never rises.
REQ-040 Reset abort: reset asserted during the second coin of total=2000 -> all outputs read 0 in the same cycle, with no o_done.
